// File: rtl/mem_load_unit.sv
// mem_load_unit: single-outstanding load unit. Each accepted load is either
// rejected at once with an address error, or issued on the bus and completed
// by an ack (lane-selected, extended data) or by a timeout (bus error).
module mem_load_unit #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 15,
  parameter logic [31:0] DM_LO       = 32'h0000_0000,
  parameter logic [31:0] DM_HI       = 32'h0000_2FFF,
  parameter logic [31:0] TC0_LO      = 32'h0000_7F00,
  parameter logic [31:0] TC0_HI      = 32'h0000_7F0B,
  parameter logic [31:0] TC1_LO      = 32'h0000_7F10,
  parameter logic [31:0] TC1_HI      = 32'h0000_7F1B,
  parameter logic [31:0] INT_LO      = 32'h0000_7F20,
  parameter logic [31:0] INT_HI      = 32'h0000_7F23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_addr,
  input  logic [2:0]        ld_type,
  input  logic              ld_ov,
  input  logic              flush,
  output logic              bus_req,
  output logic [31:0]       bus_addr,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_adel,
  output logic              rsp_berr
);

  localparam int unsigned OFF = (DATA_W == 64) ? 3 : 2;
  localparam int unsigned CW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT_CYC - 1);
  localparam logic [31:0]   ALIGN_MASK = ~(32'(DATA_W / 8) - 32'd1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [2:0] T_WORD  = 3'd0;
  localparam logic [2:0] T_HALF  = 3'd1;
  localparam logic [2:0] T_BYTE  = 3'd2;
  localparam logic [2:0] T_HALFU = 3'd3;
  localparam logic [2:0] T_BYTEU = 3'd4;
  localparam logic [2:0] T_DWORD = 3'd5;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       baddr_q, baddr_d;
  logic [OFF-1:0]    off_q, off_d;
  logic [2:0]        type_q, type_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              adel_q, adel_d;
  logic              berr_q, berr_d;

  logic              is_word, is_half, is_dword, illegal, misalign;
  logic              in_any, in_tc, adel;
  logic [DATA_W-1:0] lane, ext;

  // Inclusive window test as one unsigned compare (lo == 0 safe).
  function automatic logic in_win(input logic [31:0] a, input logic [31:0] lo,
                                  input logic [31:0] hi);
    return (a - lo) <= (hi - lo);
  endfunction

  // Address-error classification of the request presented this cycle.
  always_comb begin
    is_word  = (ld_type == T_WORD);
    is_half  = (ld_type == T_HALF) || (ld_type == T_HALFU);
    is_dword = (ld_type == T_DWORD);
    illegal  = ld_type[2] & ld_type[1];
    misalign = (is_word & (|ld_addr[1:0])) | (is_half & ld_addr[0]) |
               (is_dword & (|ld_addr[2:0]));
    in_any   = in_win(ld_addr, DM_LO, DM_HI) | in_win(ld_addr, TC0_LO, TC0_HI) |
               in_win(ld_addr, TC1_LO, TC1_HI) | in_win(ld_addr, INT_LO, INT_HI);
    in_tc    = in_win(ld_addr, TC0_LO, TC1_HI);
    adel     = ld_ov | illegal | (is_dword & (DATA_W == 32)) | misalign |
               ~in_any | (in_tc & ~is_word);
  end

  // Lane select by byte offset (aligned types have zero low bits) then extend.
  always_comb begin
    lane = bus_rdata >> {off_q, 3'b000};
    case (type_q)
      T_WORD:  ext = DATA_W'($signed(lane[31:0]));
      T_HALF:  ext = DATA_W'($signed(lane[15:0]));
      T_BYTE:  ext = DATA_W'($signed(lane[7:0]));
      T_HALFU: ext = DATA_W'(lane[15:0]);
      T_BYTEU: ext = DATA_W'(lane[7:0]);
      default: ext = lane;
    endcase
  end

  // Next-state logic: flush overrides everything and leaves the response regs alone.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    baddr_d = baddr_q;
    off_d   = off_q;
    type_d  = type_q;
    data_d  = data_q;
    adel_d  = adel_q;
    berr_d  = berr_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ld_valid) begin
            off_d  = ld_addr[OFF-1:0];
            type_d = ld_type;
            cnt_d  = '0;
            if (adel) begin
              state_d = S_RESP;
              data_d  = '0;
              adel_d  = 1'b1;
              berr_d  = 1'b0;
            end else begin
              state_d = S_WAIT;
              baddr_d = ld_addr & ALIGN_MASK;
            end
          end
        end
        S_WAIT: begin
          if (bus_ack) begin
            state_d = S_RESP;
            data_d  = ext;
            adel_d  = 1'b0;
            berr_d  = 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = S_RESP;
            data_d  = '0;
            adel_d  = 1'b0;
            berr_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      baddr_q <= '0;
      off_q   <= '0;
      type_q  <= '0;
      data_q  <= '0;
      adel_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      baddr_q <= baddr_d;
      off_q   <= off_d;
      type_q  <= type_d;
      data_q  <= data_d;
      adel_q  <= adel_d;
      berr_q  <= berr_d;
    end
  end

  assign ld_ready  = (state_q == S_IDLE);
  assign bus_req   = (state_q == S_WAIT);
  assign rsp_valid = (state_q == S_RESP);
  assign bus_addr  = baddr_q;
  assign rsp_data  = data_q;
  assign rsp_adel  = adel_q;
  assign rsp_berr  = berr_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// tb_mem_load_unit: directed and random loads against a 32-bit and a 64-bit
// instance, checked against an arithmetic model of the load rules.
module tb_mem_load_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        v32, v64;
  logic [31:0] ld_addr;
  logic [2:0]  ld_type;
  logic        ld_ov, flush, bus_ack;
  logic [63:0] bus_rdata;

  logic        rdy32, req32, val32, adel32, berr32;
  logic [31:0] ba32, d32;
  logic        rdy64, req64, val64, adel64, berr64;
  logic [31:0] ba64;
  logic [63:0] d64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_load_unit #(.DATA_W(32), .TIMEOUT_CYC(TMO)) u32 (
    .clk(clk), .reset(reset), .ld_valid(v32), .ld_ready(rdy32), .ld_addr(ld_addr),
    .ld_type(ld_type), .ld_ov(ld_ov), .flush(flush), .bus_req(req32), .bus_addr(ba32),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata[31:0]), .rsp_valid(val32), .rsp_data(d32),
    .rsp_adel(adel32), .rsp_berr(berr32));

  mem_load_unit #(.DATA_W(64), .TIMEOUT_CYC(TMO)) u64 (
    .clk(clk), .reset(reset), .ld_valid(v64), .ld_ready(rdy64), .ld_addr(ld_addr),
    .ld_type(ld_type), .ld_ov(ld_ov), .flush(flush), .bus_req(req64), .bus_addr(ba64),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .rsp_valid(val64), .rsp_data(d64),
    .rsp_adel(adel64), .rsp_berr(berr64));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {adel, data}: access size, legality and extension from plain arithmetic.
  function automatic logic [64:0] model(input int dw, input logic [31:0] a,
                                        input logic [2:0] t, input logic ov,
                                        input logic [63:0] rd);
    int size;
    bit sgn, inreg, tc, ad;
    int off;
    logic [63:0] v, dmask, vmask;
    case (t)
      3'd0:       size = 4;
      3'd1, 3'd3: size = 2;
      3'd2, 3'd4: size = 1;
      3'd5:       size = 8;
      default:    size = 0;
    endcase
    sgn   = (t <= 3'd2);
    inreg = (a <= 32'h2FFF) || (a >= 32'h7F00 && a <= 32'h7F0B) ||
            (a >= 32'h7F10 && a <= 32'h7F1B) || (a >= 32'h7F20 && a <= 32'h7F23);
    tc    = (a >= 32'h7F00 && a <= 32'h7F1B);
    ad    = ov || size == 0 || (size == 8 && dw == 32) ||
            (size != 0 && (a & 32'(size - 1)) != 32'h0) || !inreg || (tc && t != 3'd0);
    dmask = (dw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    off   = int'(a % 32'(dw / 8));
    v     = (rd & dmask) >> (8 * off);
    if (size == 8) begin
      v = rd;
    end else if (size != 0) begin
      vmask = (64'd1 << (8 * size)) - 64'd1;
      v = v & vmask;
      if (sgn && v[8 * size - 1]) v = v | ~vmask;
      v = v & dmask;
    end
    return {ad, ad ? 64'h0 : v};
  endfunction

  logic [63:0] obs_data;
  logic        obs_adel, obs_berr;

  task automatic run_load(input bit is64, input logic [31:0] a, input logic [2:0] t,
                          input logic ov, input int ack_at, input logic [63:0] rd);
    logic [64:0] m;
    logic [31:0] amask;
    logic [63:0] exp_data;
    int exp_lat, cyc;
    bit seen, saw_req, exp_berr;
    m        = model(is64 ? 64 : 32, a, t, ov, rd);
    amask    = is64 ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC;
    exp_berr = !m[64] && !(ack_at >= 1 && ack_at <= TMO);
    exp_data = exp_berr ? 64'h0 : m[63:0];
    if (m[64]) exp_lat = 1;
    else if (!exp_berr) exp_lat = ack_at + 1;
    else exp_lat = TMO + 1;
    chk("ready_before", 64'(is64 ? rdy64 : rdy32), 64'd1);
    ld_addr = a; ld_type = t; ld_ov = ov;
    if (is64) v64 = 1'b1; else v32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0; v64 = 1'b0; ld_ov = 1'b0;
    ld_addr = $urandom; ld_type = 3'($urandom);
    cyc = 1; seen = 0; saw_req = 0;
    while (!seen && cyc <= 40) begin
      if (is64 ? val64 : val32) begin
        seen = 1;
      end else begin
        if (is64 ? req64 : req32) begin
          saw_req = 1;
          chk("bus_addr", 64'(is64 ? ba64 : ba32), 64'(a & amask));
        end
        bus_ack   = (cyc == ack_at);
        bus_rdata = bus_ack ? rd : {$urandom, $urandom};
        @(posedge clk); #1;
        bus_ack = 1'b0;
        cyc++;
      end
    end
    obs_data = is64 ? d64 : {32'h0, d32};
    obs_adel = is64 ? adel64 : adel32;
    obs_berr = is64 ? berr64 : berr32;
    chk("rsp_latency", 64'(cyc), 64'(exp_lat));
    chk("bus_req_seen", 64'(saw_req), 64'(!m[64]));
    chk("rsp_adel", 64'(obs_adel), 64'(m[64]));
    chk("rsp_berr", 64'(obs_berr), 64'(exp_berr));
    chk("rsp_data", obs_data, exp_data);
    @(posedge clk); #1;
    chk("rsp_one_cycle", 64'(is64 ? val64 : val32), 64'd0);
    chk("ready_after", 64'(is64 ? rdy64 : rdy32), 64'd1);
    chk("data_held", is64 ? d64 : {32'h0, d32}, exp_data);
  endtask

  initial begin
    logic [31:0] a;
    logic [2:0]  t;
    int r;

    reset = 1'b0; v32 = 1'b0; v64 = 1'b0; ld_addr = '0; ld_type = '0;
    ld_ov = 1'b0; flush = 1'b0; bus_ack = 1'b0; bus_rdata = '0;
    #2;
    chk("reset_ready32", 64'(rdy32), 64'd1);
    chk("reset_req32", 64'(req32), 64'd0);
    chk("reset_val32", 64'(val32), 64'd0);
    chk("reset_data32", 64'(d32), 64'd0);
    chk("reset_addr64", 64'(ba64), 64'd0);
    chk("reset_flags64", 64'({adel64, berr64, val64, req64}), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // byte / unsigned byte from the top lane of a 32-bit bus
    run_load(0, 32'h0000_0003, 3'd2, 1'b0, 1, 64'h0000_0000_80FF_1234);
    chk("byte_sext", obs_data, 64'h0000_0000_FFFF_FF80);
    run_load(0, 32'h0000_0003, 3'd4, 1'b0, 1, 64'h0000_0000_80FF_1234);
    chk("byteu_zext", obs_data, 64'h0000_0000_0000_0080);

    // 64-bit bus: halfword in the top lane, word in the upper half, dword
    run_load(1, 32'h0000_0006, 3'd3, 1'b0, 1, 64'hBEEF_0000_0000_0000);
    chk("halfu_64", obs_data, 64'h0000_0000_0000_BEEF);
    run_load(1, 32'h0000_0104, 3'd0, 1'b0, 2, 64'h8765_4321_0000_0000);
    chk("word_64", obs_data, 64'hFFFF_FFFF_8765_4321);
    run_load(1, 32'h0000_0108, 3'd5, 1'b0, 1, 64'h0123_4567_89AB_CDEF);
    chk("dword_64", obs_data, 64'h0123_4567_89AB_CDEF);

    // address errors
    run_load(0, 32'h0000_7F04, 3'd1, 1'b0, 1, 64'h1);
    chk("tc_half_adel", 64'(obs_adel), 64'd1);
    run_load(0, 32'h0000_3000, 3'd0, 1'b0, 1, 64'h1);
    chk("oob_word_adel", 64'(obs_adel), 64'd1);
    run_load(0, 32'h0000_0008, 3'd5, 1'b0, 1, 64'h1);
    run_load(1, 32'h0000_7F23, 3'd2, 1'b0, 1, 64'h1);
    run_load(0, 32'h0000_7F20, 3'd0, 1'b0, 1, 64'hCAFE_F00D);
    run_load(0, 32'h0000_0010, 3'd0, 1'b1, 1, 64'h1);

    // timeout, and ack in the last WAIT cycle wins
    run_load(0, 32'h0000_0010, 3'd0, 1'b0, 0, 64'h5555_AAAA);
    chk("timeout_berr", 64'(obs_berr), 64'd1);
    run_load(0, 32'h0000_0010, 3'd0, 1'b0, TMO, 64'h5555_AAAA);
    chk("late_ack_data", obs_data, 64'h0000_0000_5555_AAAA);

    // flush in the second WAIT cycle, then a stray ack
    ld_addr = 32'h0000_0020; ld_type = 3'd0; v32 = 1'b1;
    @(posedge clk); #1; v32 = 1'b0;
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_req", 64'(req32), 64'd0);
    chk("flush_ready", 64'(rdy32), 64'd1);
    chk("flush_val", 64'(val32), 64'd0);
    bus_ack = 1'b1; bus_rdata = 64'hFFFF_FFFF;
    @(posedge clk); #1; bus_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("flush_no_rsp", 64'({val32, req32}), 64'd0);
      @(posedge clk); #1;
    end
    run_load(0, 32'h0000_0020, 3'd0, 1'b0, 1, 64'h1234_5678);

    // reset pulse mid-WAIT
    ld_addr = 32'h0000_0040; ld_type = 3'd0; v32 = 1'b1;
    @(posedge clk); #1; v32 = 1'b0;
    chk("pre_reset_req", 64'(req32), 64'd1);
    #2; reset = 1'b0; #1;
    chk("async_req", 64'(req32), 64'd0);
    chk("async_ready", 64'(rdy32), 64'd1);
    chk("async_outs", 64'({val32, adel32, berr32}), 64'd0);
    chk("async_data", 64'(d32), 64'd0);
    chk("async_addr", 64'(ba32), 64'd0);
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("post_reset_quiet", 64'({val32, req32, rdy32}), 64'd1);
    end

    // random loads over both widths
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       a = $urandom_range(0, 32'h2FFF);
        1:       a = 32'h7F00 + $urandom_range(0, 47);
        2:       a = 32'h2FF8 + $urandom_range(0, 15);
        default: a = $urandom;
      endcase
      r = $urandom_range(0, 3);
      if (r == 0) a[2:0] = 3'b000;
      else if (r == 1) a[1:0] = 2'b00;
      else if (r == 2) a[0] = 1'b0;
      t = 3'($urandom_range(0, 7));
      run_load(bit'($urandom_range(0, 1)), a, t, ($urandom_range(0, 15) == 0),
               $urandom_range(0, 5), {$urandom, $urandom});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
